cam_capture_dec: RTL and testbench
==================================

CAM_CAPTURE_DEC -- requirements
Module: cam_capture_dec

Interface
REQ-001 Parameter c_src_cols, default 160, meaning camera line length in pixels (QQVGA).
REQ-002 Parameter c_src_rows, default 120, meaning camera lines per frame.
REQ-003 Parameter c_img_cols, default 80, meaning stored image columns (c_src_cols/2).
REQ-004 Parameter c_img_rows, default 60, meaning stored image rows (c_src_rows/2).
REQ-005 Parameter c_nb_img_pxls, default 13, meaning frame-buffer address width.
REQ-006 Parameter c_nb_buf, default 12, meaning RGB444 buffer word width, packed {R[3:0],G[3:0],B[3:0]}.
REQ-007 Port clk, input, 1, meaning single clock; all inputs are synchronous to it.
REQ-008 Port rst, input, 1, meaning synchronous active-high reset.
REQ-009 Port cam_vsync, input, 1, meaning camera frame sync, high between frames.
REQ-010 Port cam_href, input, 1, meaning camera line-valid, high during active bytes.
REQ-011 Port cam_de, input, 1, meaning byte strobe, one cycle per camera byte.
REQ-012 Port cam_data, input, 8, meaning camera byte, valid when cam_de=1.
REQ-013 Port wr_we, output, 1, meaning frame-buffer write enable, one-cycle pulse per stored pixel.
REQ-014 Port wr_addr, output, c_nb_img_pxls, meaning frame-buffer write address.
REQ-015 Port wr_pxl, output, c_nb_buf, meaning pixel to be written.
REQ-016 Port frame_done, output, 1, meaning one-cycle pulse after the last pixel of a full frame is written.
REQ-017 Port fmt_err, output, 1, meaning sticky per-frame format error flag.

Function
REQ-018 cam_vsync, cam_href, cam_de and cam_data shall be registered once on input; all decisions use the registered copies.
REQ-019 FSM states: WAIT_SYNC (after reset, wait for a vsync falling edge), FRAME (between vsync falling and the next vsync rising edge), LINE (href high).
REQ-020 Transitions: WAIT_SYNC->FRAME on vsync fall; FRAME->LINE on href rise; LINE->FRAME on href fall; FRAME or LINE->WAIT_SYNC on vsync rise.
REQ-021 The vsync-fall transition into FRAME shall clear the source column and row counters, wr_addr, byte phase and fmt_err.
REQ-022 In LINE, byte phase shall toggle on each cam_de: phase 0 latches R=cam_data[3:0]; phase 1 supplies G=cam_data[7:4] and B=cam_data[3:0].
REQ-023 A phase-1 byte shall complete one source pixel and increment the source column counter.
REQ-024 A completed pixel with even source column and even source row shall be stored; all other pixels are discarded.
REQ-025 wr_we shall assert exactly 2 clk after the cycle in which the phase-1 byte is presented at the inputs with cam_de=1.
REQ-026 wr_pxl and wr_addr shall be valid in the same cycle as wr_we; wr_addr shall increment by 1 in the cycle after each write.
REQ-027 href fall shall reset byte phase and source column and increment the source row; a pending half pixel (odd byte count) shall be dropped and fmt_err set.
REQ-028 A line exceeding c_src_cols pixels, or rows exceeding c_src_rows, shall set fmt_err; the excess pixels are not stored.
REQ-029 Writes beyond address c_img_cols*c_img_rows-1 (4799) shall be suppressed; wr_addr shall saturate at 4799.
REQ-030 frame_done shall pulse 1 clk after the write to address 4799; no pulse shall occur for a short frame.
REQ-031 vsync rise before address 4799 is written shall abort the frame without frame_done; capture restarts at address 0 on the next vsync fall.
REQ-032 If cam_de coincides with an href fall, the href fall takes priority and the byte is discarded.

Reset
REQ-033 rst shall force the FSM to WAIT_SYNC, clear all counters and input registers, and drive wr_we=0, wr_addr=0, wr_pxl=0, frame_done=0 and fmt_err=0 on the next clk edge, including mid-line.
REQ-034 After reset, no write shall occur before the first complete vsync fall.

Structure
REQ-035 Image-geometry constants (source and stored cols/rows, address and buffer widths) and the RGB444 field positions shall live in a shared package also used by the colour-processing and display stages.
REQ-036 FSM state encodings shall be local to the module.
REQ-037 A sub-module cam_byte_pack (byte phase plus RGB444 assembly) is natural; the decimation, addressing and FSM remain in the top module.

Verification
REQ-038 Full 160x120 frame with pixel(c,r) = {R=c[3:0], G=r[3:0], B=0xA} -> 4800 writes; addr a holds pixel(2*(a%80), 2*(a/80)); frame_done pulses once; fmt_err=0.
REQ-039 Single byte pair 0x0F, 0x5A at column 0, row 0 -> wr_we 2 clk after the 0x5A byte, wr_pxl=0xF5A, wr_addr=0.
REQ-040 A line of 161 bytes -> the odd byte is dropped, fmt_err=1, the next line starts at phase 0, and row alignment is preserved.
REQ-041 vsync rise after 30 source lines -> frame_done never pulses; the next frame writes from address 0.
REQ-042 rst asserted mid-line at address 1234 -> all outputs 0 on the next edge; no writes until vsync fall.
REQ-043 A 200-pixel line -> writes stop at column 79 of that row and fmt_err=1.

Source files
------------

// File: rtl/cam_capture_dec_pkg.sv
// cam_capture_dec_pkg: image geometry and RGB444 layout shared by the capture, colour and display stages.
// Revision: 1.0
`default_nettype none
package cam_capture_dec_pkg;
  localparam int SRC_COLS    = 160;
  localparam int SRC_ROWS    = 120;
  localparam int IMG_COLS    = 80;
  localparam int IMG_ROWS    = 60;
  localparam int NB_IMG_PXLS = 13;
  localparam int NB_BUF      = 12;

  localparam int CH_W  = 4;
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  function automatic logic [NB_BUF-1:0] pack_rgb444(input logic [CH_W-1:0] r,
                                                    input logic [CH_W-1:0] g,
                                                    input logic [CH_W-1:0] b);
    logic [NB_BUF-1:0] pix;
    pix = '0;
    pix[R_LSB +: CH_W] = r;
    pix[G_LSB +: CH_W] = g;
    pix[B_LSB +: CH_W] = b;
    return pix;
  endfunction
endpackage
`default_nettype wire

// File: rtl/cam_capture_dec_byte_pack.sv
// cam_byte_pack: two-byte RGB444 assembly; the pixel is presented combinationally with its second byte.
// Revision: 1.0
`default_nettype none
module cam_byte_pack
  import cam_capture_dec_pkg::*;
#(
  parameter int c_nb_buf = NB_BUF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [7:0]          data,
  output logic                phase,
  output logic                pix_valid,
  output logic [c_nb_buf-1:0] pix
);
  logic [CH_W-1:0] r_nib;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
      r_nib <= '0;
    end else if (clr) begin
      phase <= 1'b0;
    end else if (en) begin
      phase <= ~phase;
      if (!phase) r_nib <= data[3:0];
    end
  end

  assign pix_valid = en & phase;
  assign pix       = c_nb_buf'(pack_rgb444(r_nib, data[7:4], data[3:0]));
endmodule
`default_nettype wire

// File: rtl/cam_capture_dec.sv
// cam_capture_dec: camera byte stream capture with 2:1 decimation into an RGB444 frame buffer.
// Revision: 1.0
`default_nettype none
module cam_capture_dec
  import cam_capture_dec_pkg::*;
#(
  parameter int c_src_cols    = SRC_COLS,
  parameter int c_src_rows    = SRC_ROWS,
  parameter int c_img_cols    = IMG_COLS,
  parameter int c_img_rows    = IMG_ROWS,
  parameter int c_nb_img_pxls = NB_IMG_PXLS,
  parameter int c_nb_buf      = NB_BUF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic                     cam_de,
  input  logic [7:0]               cam_data,
  output logic                     wr_we,
  output logic [c_nb_img_pxls-1:0] wr_addr,
  output logic [c_nb_buf-1:0]      wr_pxl,
  output logic                     frame_done,
  output logic                     fmt_err
);
  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    FRAME     = 2'd1,
    LINE      = 2'd2
  } state_t;

  localparam int COL_W = $clog2(c_src_cols + 1);
  localparam int ROW_W = $clog2(c_src_rows + 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(c_src_cols);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(c_src_rows);
  localparam logic [c_nb_img_pxls-1:0] LAST_ADDR = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);

  logic vs_q, vs_q2, hr_q, hr_q2, de_q;
  logic [7:0] data_q;
  state_t state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic full;
  logic phase, pix_valid;
  logic [c_nb_buf-1:0] pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q   <= 1'b0;
      vs_q2  <= 1'b0;
      hr_q   <= 1'b0;
      hr_q2  <= 1'b0;
      de_q   <= 1'b0;
      data_q <= '0;
    end else begin
      vs_q   <= cam_vsync;
      vs_q2  <= vs_q;
      hr_q   <= cam_href;
      hr_q2  <= hr_q;
      de_q   <= cam_de;
      data_q <= cam_data;
    end
  end

  wire vs_fall = vs_q2 & ~vs_q;
  wire vs_rise = ~vs_q2 & vs_q;
  wire hr_rise = ~hr_q2 & hr_q;
  wire hr_fall = hr_q2 & ~hr_q;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SYNC: if (vs_fall) state_nxt = FRAME;
      FRAME: begin
        if (vs_rise)      state_nxt = WAIT_SYNC;
        else if (hr_rise) state_nxt = LINE;
      end
      LINE: begin
        if (vs_rise)      state_nxt = WAIT_SYNC;
        else if (hr_fall) state_nxt = FRAME;
      end
      default: state_nxt = WAIT_SYNC;
    endcase
  end

  // A byte arriving with the href rise already belongs to the line.
  wire in_line     = hr_q & ~vs_rise & ((state == LINE) | ((state == FRAME) & hr_rise));
  wire byte_en     = in_line & de_q;
  wire frame_start = (state == WAIT_SYNC) & vs_fall;
  wire line_end    = (state == LINE) & hr_fall;
  wire col_ok      = col < COL_MAX;
  wire row_ok      = row < ROW_MAX;
  wire store       = col_ok & row_ok & ~col[0] & ~row[0] & ~full;

  cam_byte_pack #(.c_nb_buf(c_nb_buf)) u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (frame_start | line_end),
    .en        (byte_en),
    .data      (data_q),
    .phase     (phase),
    .pix_valid (pix_valid),
    .pix       (pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      full       <= 1'b0;
      wr_we      <= 1'b0;
      wr_addr    <= '0;
      wr_pxl     <= '0;
      frame_done <= 1'b0;
      fmt_err    <= 1'b0;
    end else begin
      wr_we      <= 1'b0;
      frame_done <= wr_we & (wr_addr == LAST_ADDR);
      // wr_addr holds the next target; it advances once the write has been presented.
      if (wr_we) begin
        if (wr_addr == LAST_ADDR) full <= 1'b1;
        else                      wr_addr <= wr_addr + 1'b1;
      end
      if (frame_start) begin
        col     <= '0;
        row     <= '0;
        wr_addr <= '0;
        full    <= 1'b0;
        fmt_err <= 1'b0;
      end else if (line_end) begin
        col <= '0;
        if (row != ROW_MAX) row <= row + 1'b1;
        if (phase) fmt_err <= 1'b1;
      end else if (pix_valid) begin
        if (col != COL_MAX) col <= col + 1'b1;
        if (!col_ok || !row_ok) fmt_err <= 1'b1;
        if (store) begin
          wr_we  <= 1'b1;
          wr_pxl <= pix;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cam_capture_dec.sv
// tb_cam_capture_dec: randomized camera streams checked through a write scoreboard.
// Revision: 1.0
`default_nettype none
module tb_cam_capture_dec;
  import cam_capture_dec_pkg::*;

  localparam int IMG_PX = IMG_COLS * IMG_ROWS;

  logic clk = 1'b0;
  logic rst;
  logic cam_vsync, cam_href, cam_de;
  logic [7:0] cam_data;
  logic wr_we;
  logic [12:0] wr_addr;
  logic [11:0] wr_pxl;
  logic frame_done, fmt_err;

  cam_capture_dec dut (
    .clk        (clk),
    .rst        (rst),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_de     (cam_de),
    .cam_data   (cam_data),
    .wr_we      (wr_we),
    .wr_addr    (wr_addr),
    .wr_pxl     (wr_pxl),
    .frame_done (frame_done),
    .fmt_err    (fmt_err)
  );

  typedef struct {
    logic [12:0] addr;
    logic [11:0] pxl;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_addr = 0;
  int line_row = 0;
  int done_total = 0;
  int done_base = 0;
  bit exp_fmt = 0;
  bit exp_done = 0;
  bit prev_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        done_total++;
        check_eq("done_after_last", 64'(prev_last), 64'd1);
      end
      if (wr_we === 1'b1) begin
        check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("write", {7'b0, wr_addr, wr_pxl, 32'(cyc)}, {7'b0, e.addr, e.pxl, 32'(e.cyc)});
        end
      end
      prev_last = (wr_we === 1'b1) && (wr_addr == 13'(IMG_PX - 1));
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, output int k);
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1 cam_de = 1'b0;
    end
    @(posedge clk); #1;
    cam_de   = 1'b1;
    cam_data = b;
    k        = cyc;
  endtask

  // Reference rule: keep even-column/even-row pixels of the 160x120 window, up to 4800 of them.
  task automatic model_pixel(input int c, input logic [11:0] pix, input int k);
    exp_t e;
    if (c >= SRC_COLS || line_row >= SRC_ROWS) exp_fmt = 1'b1;
    else if (c % 2 == 0 && line_row % 2 == 0 && exp_addr < IMG_PX) begin
      e.addr = 13'(exp_addr);
      e.pxl  = pix;
      e.cyc  = k + 2;
      sb.push_back(e);
      if (exp_addr == IMG_PX - 1) exp_done = 1'b1;
      exp_addr++;
    end
  endtask

  task automatic end_line(input bit coincide);
    @(posedge clk); #1 cam_de = 1'b0;
    @(posedge clk); #1;
    cam_href = 1'b0;
    cam_de   = coincide;
    cam_data = 8'($urandom);
    @(posedge clk); #1 cam_de = 1'b0;
    repeat (3) @(posedge clk);
    line_row++;
  endtask

  task automatic drive_line(input int npix, input bit odd_byte, input bit coincide,
                            input bit pattern, input bit gaps, input bit hold);
    int k;
    logic [7:0] b0, b1;
    @(posedge clk); #1;
    cam_href = 1'b1;
    cam_de   = 1'b0;
    for (int c = 0; c < npix; c++) begin
      if (pattern) begin
        b0 = {4'($urandom), 4'(c)};
        b1 = {4'(line_row), 4'hA};
      end else begin
        b0 = 8'($urandom);
        b1 = 8'($urandom);
      end
      send_byte(b0, gaps, k);
      send_byte(b1, gaps, k);
      model_pixel(c, {b0[3:0], b1}, k);
    end
    if (odd_byte) begin
      send_byte(8'($urandom), gaps, k);
      exp_fmt = 1'b1;
    end
    if (!hold) end_line(coincide);
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_de    = 1'b0;
    repeat (4) @(posedge clk);
    #1 cam_vsync = 1'b0;
    exp_addr  = 0;
    line_row  = 0;
    exp_fmt   = 1'b0;
    exp_done  = 1'b0;
    done_base = done_total;
    repeat (4) @(posedge clk);
  endtask

  task automatic frame_end();
    repeat (6) @(posedge clk);
    #1;
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    check_eq("fmt_err", 64'(fmt_err), 64'(exp_fmt));
    check_eq("frame_done_count", 64'(done_total - done_base), 64'(exp_done));
    check_eq("wr_addr_next", 64'(wr_addr), 64'((exp_addr > IMG_PX - 1) ? IMG_PX - 1 : exp_addr));
    cam_vsync = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_de    = 1'b0;
    cam_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {37'b0, wr_we, wr_addr, wr_pxl, frame_done, fmt_err}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Bytes before any vsync fall must not be stored.
    @(posedge clk); #1 cam_href = 1'b1;
    repeat (10) send_byte(8'($urandom), 1'b0, k);
    @(posedge clk); #1;
    cam_de   = 1'b0;
    cam_href = 1'b0;
    repeat (4) @(posedge clk);

    // Single 0x0F,0x5A pair.
    frame_start();
    @(posedge clk); #1 cam_href = 1'b1;
    send_byte(8'h0F, 1'b0, k);
    send_byte(8'h5A, 1'b0, k);
    model_pixel(0, 12'hF5A, k);
    end_line(1'b0);
    frame_end();

    // Full frame with the coordinate pattern.
    frame_start();
    for (int r = 0; r < SRC_ROWS; r++) drive_line(SRC_COLS, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame_end();

    // Frame aborted after 30 lines.
    frame_start();
    for (int r = 0; r < 30; r++) drive_line(SRC_COLS, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame_end();

    // 161-byte line whose extra byte is followed by one coinciding with href fall.
    frame_start();
    drive_line(80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) drive_line(SRC_COLS, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame_end();

    // Over-long 200-pixel line.
    frame_start();
    drive_line(200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) drive_line(SRC_COLS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame_end();

    // Too many rows of short lines.
    frame_start();
    for (int r = 0; r < SRC_ROWS + 2; r++) drive_line(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame_end();

    // Reset mid-line once address 1234 is next.
    frame_start();
    for (int r = 0; r < 30; r++) drive_line(SRC_COLS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_line(68, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 cam_de = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("sb_drained_pre_reset", 64'(sb.size()), 64'd0);
    check_eq("wr_addr_pre_reset", 64'(wr_addr), 64'(exp_addr));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_midline", {37'b0, wr_we, wr_addr, wr_pxl, frame_done, fmt_err}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) send_byte(8'($urandom), 1'b0, k);
    @(posedge clk); #1;
    cam_de   = 1'b0;
    cam_href = 1'b0;
    repeat (6) @(posedge clk);
    #1 check_eq("no_write_after_reset", 64'(wr_addr), 64'd0);
    frame_start();
    for (int r = 0; r < 3; r++) drive_line(SRC_COLS, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame_end();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
